// File: rtl/mem_resp_stage.sv
// mem_resp_stage: MEM stage between EX and WB. Holds up to DEPTH in-flight
// instructions whose data-bus requests were accepted in EX and matches the
// in-order data_ok responses to them. Applies byte/half/word load alignment
// with zero/sign extension. Drains orphaned responses after a flush.
//
// Optional feature: define MEM_RESP_BYPASS_EN to let a response for a waiting
// head entry reach WB in the same cycle it arrives. Without it, responses are
// always registered first and out_valid is a register output.
module mem_resp_stage #(
  parameter int DEPTH  = 2,
  parameter int PASS_W = 64
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PASS_W-1:0] in_pass,
  input  logic [31:0]       in_result,
  input  logic              in_is_load,
  input  logic              in_wait_resp,
  input  logic [1:0]        in_size,
  input  logic              in_signed,
  input  logic [1:0]        in_addr_lo,
  input  logic              data_sram_data_ok,
  input  logic [31:0]       data_sram_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PASS_W-1:0] out_pass,
  output logic [31:0]       out_result,
  output logic              busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] ONE = PW'(1);

  // Entry storage
  logic [PASS_W-1:0] e_pass    [DEPTH];
  logic [31:0]       e_result  [DEPTH];
  logic              e_is_load [DEPTH];
  logic [1:0]        e_size    [DEPTH];
  logic              e_signed  [DEPTH];
  logic [1:0]        e_addr_lo [DEPTH];
  logic              e_wait    [DEPTH];
  logic              e_got     [DEPTH];
  logic [31:0]       e_rdata   [DEPTH];

  // Pointers and counters
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] resp_ptr;
  logic [PW-1:0] discard_cnt;
  logic          out_valid_q;

  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;
  logic          route;
  logic          drop_resp;
  logic          flush_dec;
  logic          bypass;

  logic          tgt_found;
  logic [PW-1:0] tgt_ptr;
  logic [AW-1:0] tgt_idx;
  logic [PW-1:0] pend_cnt;

  logic [PW-1:0] wr_ptr_n;
  logic [PW-1:0] rd_ptr_n;
  logic [AW-1:0] rd_idx_n;
  logic          head_done_n;

  // Extract the addressed lane of a load response and extend it.
  function automatic logic [31:0] align_load(
    input logic [31:0] rd,
    input logic [1:0]  sz,
    input logic        sgn,
    input logic [1:0]  al
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (al)
      2'd0:    b = rd[7:0];
      2'd1:    b = rd[15:8];
      2'd2:    b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = al[1] ? rd[31:16] : rd[15:0];
    case (sz)
      2'b00:   r = {{24{sgn & b[7]}}, b};
      2'b01:   r = {{16{sgn & h[15]}}, h};
      default: r = rd;
    endcase
    return r;
  endfunction

  assign wr_idx    = wr_ptr[AW-1:0];
  assign rd_idx    = rd_ptr[AW-1:0];
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);
  assign in_ready  = !full;
  assign busy      = !empty || (discard_cnt != '0);

  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;
  assign drop_resp = data_sram_data_ok && (discard_cnt != '0);
  assign route     = data_sram_data_ok && (discard_cnt == '0) && tgt_found && !flush;
  assign flush_dec = data_sram_data_ok && ((discard_cnt != '0) || tgt_found);
  assign tgt_idx   = tgt_ptr[AW-1:0];

  // Find the oldest entry still owed a response and count all such entries.
  always_comb begin : scan
    logic [PW-1:0] kk;
    logic [PW-1:0] p;
    logic [PW-1:0] occ;
    tgt_found = 1'b0;
    tgt_ptr   = resp_ptr;
    pend_cnt  = '0;
    occ       = wr_ptr - resp_ptr;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      kk = PW'(k);
      p  = resp_ptr + kk;
      if ((kk < occ) && e_wait[p[AW-1:0]] && !e_got[p[AW-1:0]]) begin
        pend_cnt = pend_cnt + ONE;
        if (!tgt_found) begin
          tgt_found = 1'b1;
          tgt_ptr   = p;
        end
      end
    end
  end

`ifdef MEM_RESP_BYPASS_EN
  logic head_wait;
  assign head_wait = e_wait[rd_idx] && !e_got[rd_idx];
  assign bypass    = !empty && head_wait && data_sram_data_ok && (discard_cnt == '0);
`else
  assign bypass    = 1'b0;
`endif

  assign out_valid = out_valid_q || bypass;
  assign out_pass  = e_pass[rd_idx];

  // Head result: ALU result for non-loads, aligned memory data for loads.
  always_comb begin
    logic [31:0] src;
    src = bypass ? data_sram_rdata : e_rdata[rd_idx];
    if (e_is_load[rd_idx])
      out_result = align_load(src, e_size[rd_idx], e_signed[rd_idx], e_addr_lo[rd_idx]);
    else
      out_result = e_result[rd_idx];
  end

  // Next-state head completion so out_valid can be a plain register.
  always_comb begin
    wr_ptr_n = push ? (wr_ptr + ONE) : wr_ptr;
    rd_ptr_n = pop ? (rd_ptr + ONE) : rd_ptr;
    rd_idx_n = rd_ptr_n[AW-1:0];
    if (rd_ptr_n == wr_ptr_n)
      head_done_n = 1'b0;
    else if (push && (rd_ptr_n == wr_ptr))
      head_done_n = !in_wait_resp;
    else
      head_done_n = !e_wait[rd_idx_n] || e_got[rd_idx_n] || (route && (tgt_ptr == rd_ptr_n));
  end

  // Entry storage: write on push, capture response data on routed data_ok.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (push && (wr_idx == AW'(i))) begin
        e_pass[i]    <= in_pass;
        e_result[i]  <= in_result;
        e_is_load[i] <= in_is_load;
        e_size[i]    <= in_size;
        e_signed[i]  <= in_signed;
        e_addr_lo[i] <= in_addr_lo;
        e_wait[i]    <= in_wait_resp;
        e_got[i]     <= 1'b0;
      end else if (route && (tgt_idx == AW'(i))) begin
        e_got[i]     <= 1'b1;
        e_rdata[i]   <= data_sram_rdata;
      end
    end
  end

  // Pointer, discard counter and out_valid register update.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      resp_ptr    <= '0;
      discard_cnt <= '0;
      out_valid_q <= 1'b0;
    end else if (flush) begin
      rd_ptr      <= wr_ptr;
      resp_ptr    <= wr_ptr;
      out_valid_q <= 1'b0;
      // Orphans still draining from an earlier flush stay counted ahead of
      // the newly orphaned entries; a data_ok this cycle retires one of them.
      discard_cnt <= discard_cnt + pend_cnt - (flush_dec ? ONE : '0);
    end else begin
      wr_ptr      <= wr_ptr_n;
      rd_ptr      <= rd_ptr_n;
      out_valid_q <= head_done_n;
      // resp_ptr never lags rd_ptr: popping the entry it points at moves it on.
      if (route)
        resp_ptr <= tgt_ptr + ONE;
      else if (pop && (resp_ptr == rd_ptr))
        resp_ptr <= rd_ptr + ONE;
      if (drop_resp)
        discard_cnt <= discard_cnt - ONE;
    end
  end

endmodule
